uart_cmd_assembler: RTL and testbench

// - Sits directly downstream of the UART receiver. Consumes its rdy/rx_data byte stream.
// - Acks each byte with a clr_rdy pulse.
// - Assembles three consecutive bytes into one 24-bit command {opcode, data_hi, data_lo}.
// - Presents the command to the control logic with a level cmd_rdy / clr_cmd_rdy handshake.
// - Discards partial frames on an inter-byte timeout.
//

---
 rtl/uart_cmd_assembler.sv | 215 +++++++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// -----------------------------------------------------------------------------
// uart_cmd_assembler
//
// Purpose:
//   Sits directly behind the UART receiver and turns its byte stream into
//   24-bit commands {opcode, data_hi, data_lo}. Every byte taken from the
//   receiver is acknowledged with a one-cycle clr_rx_rdy pulse. A finished
//   command is offered to the control logic through a level cmd_rdy that the
//   consumer drops with clr_cmd_rdy. If the gap between two bytes of one frame
//   grows too long, the partial frame is thrown away and frame_err is raised.
//
// Optional feature (macro CMD_CHKSUM_EN):
//   When defined, each frame carries a fourth checksum byte equal to
//   ~(byte0 + byte1 + byte2) (8-bit modulo sum). A bad checksum leaves cmd and
//   cmd_rdy alone and raises frame_err. When undefined, frames are three bytes
//   and frame_err is only raised by the inter-byte timeout.
//
// Parameters:
//   TIMEOUT_CYC  max clk cycles allowed between accepted bytes of one frame
//   TO_W         timeout counter width, 2**TO_W must exceed TIMEOUT_CYC
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_rdy       in   byte-valid level from the UART receiver
//   rx_data      in   received byte, valid while rx_rdy is high
//   clr_rx_rdy   out  one-cycle ack back to the receiver
//   cmd          out  assembled command, first byte in [23:16]
//   cmd_rdy      out  command-valid level
//   clr_cmd_rdy  in   consumer ack, clears cmd_rdy
//   frame_err    out  sticky flag, last frame was aborted
// -----------------------------------------------------------------------------
module uart_cmd_assembler #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_W        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err
);

`ifdef CMD_CHKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2,
    GOT3 = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [7:0]      byte0_q, byte0_d;
  logic [7:0]      byte1_q, byte1_d;
`ifdef CMD_CHKSUM_EN
  logic [7:0]      byte2_q, byte2_d;
  logic [7:0]      chk_exp;
`endif
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            clr_rx_rdy_q, clr_rx_rdy_d;
  logic [23:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            frame_err_q, frame_err_d;

  logic            accept;
  logic            timeout_hit;

  // The receiver's rdy is still high during our ack cycle because it only
  // clears on the edge after seeing clr_rx_rdy; masking with the registered
  // ack keeps that stale level from being taken as a second byte.
  assign accept      = rx_rdy & ~clr_rx_rdy_q;
  assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_LAST);

`ifdef CMD_CHKSUM_EN
  assign chk_exp = ~(byte0_q + byte1_q + byte2_q);
`endif

  // Next-state logic. An accept always takes priority over a timeout in the
  // same cycle, and a completion takes priority over clr_cmd_rdy because the
  // completion assignment comes after the clear.
  always_comb begin
    state_d      = state_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
`ifdef CMD_CHKSUM_EN
    byte2_d      = byte2_q;
`endif
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    frame_err_d  = frame_err_q;
    clr_rx_rdy_d = accept;

    // Counter sits at 0 in IDLE and restarts on every accepted byte.
    if (accept || (state_q == IDLE)) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          byte0_d   = rx_data;
          // A new frame invalidates the previous command.
          cmd_rdy_d = 1'b0;
          state_d   = GOT1;
        end
      end

      GOT1: begin
        if (accept) begin
          byte1_d = rx_data;
          state_d = GOT2;
        end
      end

      GOT2: begin
        if (accept) begin
`ifdef CMD_CHKSUM_EN
          byte2_d     = rx_data;
          state_d     = GOT3;
`else
          cmd_d       = {byte0_q, byte1_q, rx_data};
          cmd_rdy_d   = 1'b1;
          frame_err_d = 1'b0;
          state_d     = IDLE;
`endif
        end
      end

`ifdef CMD_CHKSUM_EN
      GOT3: begin
        if (accept) begin
          if (rx_data == chk_exp) begin
            cmd_d       = {byte0_q, byte1_q, byte2_q};
            cmd_rdy_d   = 1'b1;
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort a stalled partial frame; accept wins over an expiring counter.
    if (timeout_hit && !accept) begin
      byte0_d     = '0;
      byte1_d     = '0;
`ifdef CMD_CHKSUM_EN
      byte2_d     = '0;
`endif
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end
  end

  // State, byte registers and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte0_q      <= '0;
      byte1_q      <= '0;
`ifdef CMD_CHKSUM_EN
      byte2_q      <= '0;
`endif
      to_cnt_q     <= '0;
      clr_rx_rdy_q <= 1'b0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
`ifdef CMD_CHKSUM_EN
      byte2_q      <= byte2_d;
`endif
      to_cnt_q     <= to_cnt_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_assembler
//
// Directed testbench for uart_cmd_assembler with TIMEOUT_CYC = 1000. A small
// UART receiver model raises rx_rdy with a byte and drops it once it sees
// clr_rx_rdy (optionally one cycle late to mimic a stale rdy). All stimulus
// is applied and all outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_cmd_assembler;

  localparam int TIMEOUT_CYC = 1000;
`ifdef CMD_CHKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        frame_err;

  int tests_run = 0;
  int tests_failed = 0;
  int ack_cnt = 0;

  uart_cmd_assembler #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Counts clock cycles in which the ack was high.
  always @(posedge clk) begin
    if (clr_rx_rdy === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // UART receiver model: present a byte, wait for the ack, then drop rdy.
  // Called at a falling edge; returns at the falling edge after the ack edge
  // (one cycle later when stale is set). ack_cmd pulses clr_cmd_rdy so that it
  // coincides with the accept edge of this byte.
  task automatic send_byte(input logic [7:0] b, input bit stale, input bit ack_cmd);
    bit seen;
    seen = 1'b0;
    rx_data = b;
    rx_rdy = 1'b1;
    if (ack_cmd) clr_cmd_rdy = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (clr_rx_rdy === 1'b1) seen = 1'b1;
    end
    clr_cmd_rdy = 1'b0;
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ack_wait: no clr_rx_rdy for byte %02h within 8 cycles", b);
    end
    if (stale) @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  // Sends the last data byte and, in checksum builds, the checksum byte.
  task automatic send_last(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit stale, input bit ack_cmd);
    logic [7:0] chk;
    chk = ~(b0 + b1 + b2);
    send_byte(b2, stale, ack_cmd && (FRAME_LEN == 3));
    if (FRAME_LEN == 4) send_byte(chk, stale, ack_cmd);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit stale,
                            input bit ack_cmd, input int gap);
    send_byte(b0, stale, 1'b0);
    repeat (gap) @(negedge clk);
    send_byte(b1, stale, 1'b0);
    repeat (gap) @(negedge clk);
    send_last(b0, b1, b2, stale, ack_cmd);
  endtask

  task automatic pulse_clr_cmd();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (cmd !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cmd: got %06h expected 000000", cmd);
    end
    tests_run++;
    if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got rdy=%b ack=%b err=%b expected 0 0 0",
               cmd_rdy, clr_rx_rdy, frame_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal();
    int a0;
    a0 = ack_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    send_byte(8'h12, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL normal_early: cmd_rdy got %b expected 0 before final byte", cmd_rdy);
    end
    send_last(8'hA5, 8'h12, 8'h34, 1'b0, 1'b0);
    tests_run++;
    if (cmd !== 24'hA51234 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL normal_cmd: got %06h rdy=%b expected A51234 rdy=1", cmd, cmd_rdy);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL normal_hold: cmd_rdy got %b expected 1", cmd_rdy);
    end
    tests_run++;
    if (ack_cnt - a0 !== FRAME_LEN) begin
      tests_failed++;
      $display("[TB] FAIL normal_acks: got %0d ack cycles expected %0d", ack_cnt - a0, FRAME_LEN);
    end
    pulse_clr_cmd();
    tests_run++;
    if (cmd_rdy !== 1'b0 || cmd !== 24'hA51234 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL normal_clear: got rdy=%b cmd=%06h err=%b expected 0 A51234 0",
               cmd_rdy, cmd, frame_err);
    end
  endtask

  task automatic test_stale_rdy();
    int a0;
    a0 = ack_cnt;
    send_frame(8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 5);
    tests_run++;
    if (cmd !== 24'h010203 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stale_cmd: got %06h rdy=%b expected 010203 rdy=1", cmd, cmd_rdy);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (ack_cnt - a0 !== FRAME_LEN) begin
      tests_failed++;
      $display("[TB] FAIL stale_acks: got %0d ack cycles expected %0d", ack_cnt - a0, FRAME_LEN);
    end
  endtask

  task automatic test_timeout();
    // Byte accepted at edge E0; the abort lands exactly at E0+1000.
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_early: frame_err got %b expected 0 one cycle before limit", frame_err);
    end
    @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b1 || cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_fire: got err=%b rdy=%b expected err=1 rdy=0", frame_err, cmd_rdy);
    end
    send_frame(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0, 2);
    tests_run++;
    if (cmd !== 24'h0A0B0C || frame_err !== 1'b0 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_recover: got %06h err=%b rdy=%b expected 0A0B0C 0 1",
               cmd, frame_err, cmd_rdy);
    end
    pulse_clr_cmd();
    // Second byte lands in the cycle where the counter shows 999.
    send_byte(8'h61, 1'b0, 1'b0);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    send_byte(8'h62, 1'b0, 1'b0);
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_edge_err: frame_err got %b expected 0", frame_err);
    end
    send_last(8'h61, 8'h62, 8'h63, 1'b0, 1'b0);
    tests_run++;
    if (cmd !== 24'h616263 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_edge_cmd: got %06h rdy=%b expected 616263 rdy=1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_simultaneous();
    send_frame(8'h5A, 8'h6B, 8'h7C, 1'b0, 1'b1, 3);
    tests_run++;
    if (cmd !== 24'h5A6B7C || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL simul_win: got %06h rdy=%b expected 5A6B7C rdy=1", cmd, cmd_rdy);
    end
    repeat (3) @(negedge clk);
    send_byte(8'h99, 1'b0, 1'b0);
    tests_run++;
    if (cmd_rdy !== 1'b0 || cmd !== 24'h5A6B7C) begin
      tests_failed++;
      $display("[TB] FAIL simul_newframe: got rdy=%b cmd=%06h expected 0 5A6B7C", cmd_rdy, cmd);
    end
    send_byte(8'h98, 1'b0, 1'b0);
    send_last(8'h99, 8'h98, 8'h97, 1'b0, 1'b0);
    tests_run++;
    if (cmd !== 24'h999897 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL simul_b2b: got %06h rdy=%b expected 999897 rdy=1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_async_reset();
    // Reset in the ack cycle of a completed frame.
    send_frame(8'hC0, 8'hFF, 8'hEE, 1'b0, 1'b0, 2);
    tests_run++;
    if (clr_rx_rdy !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== 24'hC0FFEE) begin
      tests_failed++;
      $display("[TB] FAIL areset_pre: got ack=%b rdy=%b cmd=%06h expected 1 1 C0FFEE",
               clr_rx_rdy, cmd_rdy, cmd);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cmd !== 24'h0 || cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL areset_a: got cmd=%06h rdy=%b ack=%b err=%b expected all 0",
               cmd, cmd_rdy, clr_rx_rdy, frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset with a partial frame pending and frame_err set.
    send_byte(8'h44, 1'b0, 1'b0);
    repeat (TIMEOUT_CYC + 1) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL areset_seterr: frame_err got %b expected 1", frame_err);
    end
    send_byte(8'h77, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (frame_err !== 1'b0 || cmd !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL areset_b: got err=%b cmd=%06h expected 0 000000", frame_err, cmd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 2);
    tests_run++;
    if (cmd !== 24'h112233 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL areset_frame: got %06h rdy=%b expected 112233 rdy=1", cmd, cmd_rdy);
    end
  endtask

`ifdef CMD_CHKSUM_EN
  task automatic test_checksum();
    send_byte(8'h10, 1'b0, 1'b0);
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h30, 1'b0, 1'b0);
    send_byte(8'h9F, 1'b0, 1'b0);
    tests_run++;
    if (cmd !== 24'h102030 || cmd_rdy !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL chk_good: got %06h rdy=%b err=%b expected 102030 1 0",
               cmd, cmd_rdy, frame_err);
    end
    send_byte(8'h10, 1'b0, 1'b0);
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h30, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    tests_run++;
    if (frame_err !== 1'b1 || cmd !== 24'h102030 || cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL chk_bad: got err=%b cmd=%06h rdy=%b expected 1 102030 0",
               frame_err, cmd, cmd_rdy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_stale_rdy();
    test_timeout();
    test_simultaneous();
    test_async_reset();
`ifdef CMD_CHKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
